add_sub_checker: RTL

Self-checking stimulus/response engine for the 4-bit `add_sub` adder/subtractor. It drives every operand/mode combination onto the DUT inputs and samples the DUT's `sum`/`cout` after a settle window. Each result is compared against an internal golden model, and the checker reports the error count plus the first failing vector. It sits opposite `add_sub` on the board/FPGA harness, so exhaustive verification runs in hardware instead of a simulator testbench.

---
 rtl/add_sub_pkg.sv | 36 +++
 rtl/add_sub_checker_if.sv | 26 ++
 rtl/add_sub_ref.sv | 23 ++
 rtl/add_sub_checker.sv | 127 ++++++++++++
 4 files changed

// File: rtl/add_sub_pkg.sv
// rtl/add_sub_pkg.sv - shared constants, FSM state and record types for the add_sub checker
package add_sub_pkg;

  localparam int WIDTH       = 4;
  localparam int SETTLE      = 2;
  localparam int IDX_W       = 2 * WIDTH + 1;
  localparam int ERR_W       = 2 * WIDTH + 2;
  localparam int PH_W        = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam int NUM_VECTORS = 1 << IDX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic             s;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } vec_t;

  typedef struct packed {
    vec_t             vec;
    logic [WIDTH:0]   sum;
    logic             cout;
  } fail_rec_t;

  // Vector index is {s, a, b} with b in the LSBs, so it maps straight onto vec_t.
  function automatic vec_t idx_to_vec(input logic [IDX_W-1:0] idx);
    vec_t v;
    v = vec_t'(idx);
    return v;
  endfunction

endpackage

// File: rtl/add_sub_checker_if.sv
// rtl/add_sub_checker_if.sv - operand/result bus between the checker and the add_sub under test
interface add_sub_checker_if import add_sub_pkg::*; ();

  logic [WIDTH-1:0] dut_a;
  logic [WIDTH-1:0] dut_b;
  logic             dut_s;
  logic [WIDTH:0]   dut_sum;
  logic             dut_cout;

  modport master (
    output dut_a,
    output dut_b,
    output dut_s,
    input  dut_sum,
    input  dut_cout
  );

  modport slave (
    input  dut_a,
    input  dut_b,
    input  dut_s,
    output dut_sum,
    output dut_cout
  );

endinterface

// File: rtl/add_sub_ref.sv
// rtl/add_sub_ref.sv - combinational golden model of the add_sub adder/subtractor
module add_sub_ref import add_sub_pkg::*; (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH:0]   sum_e,
  output logic             cout_e
);

  // Subtract reports "no borrow" on cout, the inverse of the extended sign bit.
  always_comb begin
    sum_e  = '0;
    cout_e = 1'b0;
    if (s) begin
      sum_e  = {1'b0, a} - {1'b0, b};
      cout_e = ~sum_e[WIDTH];
    end else begin
      sum_e  = {1'b0, a} + {1'b0, b};
      cout_e = sum_e[WIDTH];
    end
  end

endmodule

// File: rtl/add_sub_checker.sv
// rtl/add_sub_checker.sv - exhaustive sweep engine: drives every vector, compares, records first failure
module add_sub_checker import add_sub_pkg::*; (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  add_sub_checker_if.master     dut,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_count,
  output logic                  fail_valid,
  output logic [WIDTH-1:0]      fail_a,
  output logic [WIDTH-1:0]      fail_b,
  output logic                  fail_s,
  output logic [WIDTH:0]        fail_sum,
  output logic                  fail_cout
);

  localparam logic [IDX_W-1:0] IDX_LAST  = {IDX_W{1'b1}};
  localparam logic [PH_W-1:0]  PH_SAMPLE = PH_W'(SETTLE);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fail_valid_q, fail_valid_d;
  fail_rec_t        fail_q, fail_d;

  vec_t             cur_vec;
  logic [WIDTH:0]   sum_e;
  logic             cout_e;
  logic             mismatch;

  // The applied vector is the index register itself, so dut_* are registered outputs.
  assign cur_vec   = idx_to_vec(idx_q);
  assign dut.dut_a = cur_vec.a;
  assign dut.dut_b = cur_vec.b;
  assign dut.dut_s = cur_vec.s;

  add_sub_ref u_ref (
    .a      (cur_vec.a),
    .b      (cur_vec.b),
    .s      (cur_vec.s),
    .sum_e  (sum_e),
    .cout_e (cout_e)
  );

  assign mismatch = (dut.dut_sum != sum_e) || (dut.dut_cout != cout_e);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    ph_d         = ph_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_d       = fail_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = RUN;
          idx_d        = '0;
          ph_d         = '0;
          err_d        = '0;
          fail_valid_d = 1'b0;
          fail_d       = '0;
        end
      end

      RUN: begin
        if (ph_q == PH_SAMPLE) begin
          if (mismatch) begin
            if (err_q != {ERR_W{1'b1}}) begin
              err_d = err_q + 1'b1;
            end
            if (!fail_valid_q) begin
              fail_valid_d = 1'b1;
              fail_d.vec   = cur_vec;
              fail_d.sum   = dut.dut_sum;
              fail_d.cout  = dut.dut_cout;
            end
          end
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
            ph_d  = '0;
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      ph_q         <= '0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_q       <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      ph_q         <= ph_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_q       <= fail_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign pass       = done && (err_q == '0);
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_a     = fail_q.vec.a;
  assign fail_b     = fail_q.vec.b;
  assign fail_s     = fail_q.vec.s;
  assign fail_sum   = fail_q.sum;
  assign fail_cout  = fail_q.cout;

endmodule
